// File: rtl/bl_access_seq_pkg.sv
// Shared types and helpers for the bitline access sequencer.
package bl_access_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ACC,
    SENSE,
    RECOV
  } bl_state_e;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A mux ratio of 1 still carries a 1-bit select so the port never collapses.
  function automatic int sel_width(input int mux);
    return (mux > 1) ? $clog2(mux) : 1;
  endfunction

endpackage

// File: rtl/bl_access_seq_if.sv
// Request/response bundle between the SRAM controller and the bitline sequencer.
interface bl_access_seq_if #(
  parameter int WORD = 4,
  parameter int SELW = 2
) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_rd_wr;
  logic [SELW-1:0] req_sel;
  logic [WORD-1:0] req_wdata;
  logic [WORD-1:0] rdata;
  logic            rd_err;
  logic            done;

  modport master (
    output req_valid, req_rd_wr, req_sel, req_wdata,
    input  req_ready, rdata, rd_err, done
  );

  modport slave (
    input  req_valid, req_rd_wr, req_sel, req_wdata,
    output req_ready, rdata, rd_err, done
  );

endinterface

// File: rtl/bl_access_seq_phase_timer.sv
// Loadable down-counter that times each sequencer phase and flags zero.
module bl_access_seq_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bl_access_seq.sv
// Bitline access sequencer: one read/write per handshake, column mux select,
// precharge / wordline / write-drive / sense-enable phase timing.
module bl_access_seq
  import bl_access_seq_pkg::*;
#(
  parameter int COLS    = 16,
  parameter int MUX     = 4,
  parameter int PRE_CYC = 2,
  parameter int ACC_CYC = 2,
  parameter int SE_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bl_access_seq_if.slave           bus,
  input  logic [COLS-1:0]          bl_rd,
  input  logic [COLS-1:0]          blb_rd,
  output logic [COLS-1:0]          bl_col,
  output logic [COLS-1:0]          blb_col,
  output logic                     pre_en,
  output logic                     wl_en,
  output logic                     sae
);

  localparam int WORD = COLS / MUX;
  localparam int SELW = sel_width(MUX);
  localparam int MAXC = max3(PRE_CYC, ACC_CYC, SE_CYC);
  localparam int TW   = $clog2(MAXC) + 1;

  bl_state_e state_q, state_d;

  logic            rd_wr_q;
  logic [SELW-1:0] sel_q;
  logic [WORD-1:0] wdata_q;
  logic [SELW-1:0] sel_eff;

  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;

  logic            pre_en_q, pre_en_d;
  logic            wl_en_q, wl_en_d;
  logic            sae_q, sae_d;
  logic            done_q, done_d;
  logic [COLS-1:0] bl_col_q, bl_col_d;
  logic [COLS-1:0] blb_col_q, blb_col_d;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic            rd_err_q, rd_err_d;

  logic [COLS-1:0] wr_bl, wr_blb;
  logic [WORD-1:0] rd_bit, rd_bad;

  logic accept;

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign sel_eff = (MUX > 1) ? sel_q : '0;

  bl_access_seq_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Per data bit: write drive onto the selected column, gather of the sensed pair.
  for (genvar i = 0; i < WORD; i++) begin : g_word
    logic bit_v, bad_v;

    for (genvar j = 0; j < MUX; j++) begin : g_col
      assign wr_bl[i*MUX+j]  = (sel_eff == SELW'(j)) ?  wdata_q[i] : 1'b1;
      assign wr_blb[i*MUX+j] = (sel_eff == SELW'(j)) ? ~wdata_q[i] : 1'b1;
    end

    // Pick the selected pair of this group and flag it if it never split.
    always_comb begin
      bit_v = 1'b0;
      bad_v = 1'b0;
      for (int j = 0; j < MUX; j++) begin
        if (sel_eff == SELW'(j)) begin
          bit_v = bl_rd[i*MUX+j];
          bad_v = (bl_rd[i*MUX+j] == blb_rd[i*MUX+j]);
        end
      end
    end

    assign rd_bit[i] = bit_v;
    assign rd_bad[i] = bad_v;
  end

  // Phase sequencing: each phase loads its length minus one and exits on zero.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = PRE;
          tmr_load = 1'b1;
          tmr_val  = TW'(PRE_CYC - 1);
        end
      end
      PRE: begin
        if (tmr_zero) begin
          state_d  = ACC;
          tmr_load = 1'b1;
          tmr_val  = TW'(ACC_CYC - 1);
        end
      end
      ACC: begin
        if (tmr_zero) begin
          if (rd_wr_q == RD) begin
            state_d  = SENSE;
            tmr_load = 1'b1;
            tmr_val  = TW'(SE_CYC - 1);
          end else begin
            state_d = RECOV;
          end
        end
      end
      SENSE: begin
        if (tmr_zero) begin
          state_d = RECOV;
        end
      end
      RECOV: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    pre_en_d  = 1'b1;
    wl_en_d   = 1'b0;
    sae_d     = 1'b0;
    done_d    = 1'b0;
    bl_col_d  = '1;
    blb_col_d = '1;
    rdata_d   = rdata_q;
    rd_err_d  = rd_err_q;
    case (state_d)
      ACC: begin
        pre_en_d = 1'b0;
        wl_en_d  = 1'b1;
        if (rd_wr_q == WR) begin
          bl_col_d  = wr_bl;
          blb_col_d = wr_blb;
        end
      end
      SENSE: begin
        pre_en_d = 1'b0;
        sae_d    = 1'b1;
      end
      RECOV: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
    if (state_q == SENSE && tmr_zero) begin
      rdata_d  = rd_bit;
      rd_err_d = |rd_bad;
    end
  end

  // Request fields are captured only on the accepting handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_wr_q <= WR;
      sel_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rd_wr_q <= bus.req_rd_wr;
      sel_q   <= bus.req_sel;
      wdata_q <= bus.req_wdata;
    end
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pre_en_q  <= 1'b1;
      wl_en_q   <= 1'b0;
      sae_q     <= 1'b0;
      done_q    <= 1'b0;
      bl_col_q  <= '1;
      blb_col_q <= '1;
      rdata_q   <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_en_q  <= pre_en_d;
      wl_en_q   <= wl_en_d;
      sae_q     <= sae_d;
      done_q    <= done_d;
      bl_col_q  <= bl_col_d;
      blb_col_q <= blb_col_d;
      rdata_q   <= rdata_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rdata     = rdata_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.done      = done_q;
  assign bl_col        = bl_col_q;
  assign blb_col       = blb_col_q;
  assign pre_en        = pre_en_q;
  assign wl_en         = wl_en_q;
  assign sae           = sae_q;

  a_wl_sae_excl: assert property (@(posedge clk) !(wl_en_q && sae_q));
  a_wl_pre_excl: assert property (@(posedge clk) !(wl_en_q && pre_en_q));

endmodule
